// File: rtl/pipe_adder_pkg.sv
// Shared types and configuration helpers for the pipe_adder slice.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Upper bound on WIDTH; stage payloads are sized to it and the unused top bits fold away.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_t;

  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages != 0) && (stages <= width) && (width <= MAX_W) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, reused from the original ripple adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_adder_chunk.sv
// adder_chunk: W-bit combinational ripple of fulladder cells; also exposes the carry into the MSB.
module adder_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fulladder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake and global stall.
// Subtraction is built only when PIPE_ADDER_SUB_EN is defined; otherwise sub is ignored.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

`ifdef PIPE_ADDER_SUB_EN
  op_e op;
  assign op      = sub ? OP_SUB : OP_ADD;
  assign b_eff   = (op == OP_SUB) ? ~b : b;
  assign cin_eff = (op == OP_SUB) ? ~cin : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign cin_eff    = cin;
`endif

  // The inverted b travels with its transaction, so later stages need no knowledge of the op.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           cur;
    stage_t           nxt;
    stage_t           q;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             cm;

    if (k == 0) begin : g_src
      always_comb begin
        cur       = '0;
        cur.valid = in_valid;
        cur.carry = cin_eff;
        cur.a     = MAX_W'(a);
        cur.b     = MAX_W'(b_eff);
      end
    end else begin : g_src
      assign cur = g_stage[k-1].q;
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a    (cur.a[k*CHUNK +: CHUNK]),
      .b    (cur.b[k*CHUNK +: CHUNK]),
      .cin  (cur.carry),
      .sum  (s),
      .cout (co),
      .c_msb(cm)
    );

    always_comb begin
      nxt                       = cur;
      nxt.sum[k*CHUNK +: CHUNK] = s;
      nxt.carry                 = co;
      nxt.ovf                   = cm ^ co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (en) begin
        q <= nxt;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].q.valid;
  assign sum       = g_stage[STAGES-1].q.sum[WIDTH-1:0];
  assign cout      = g_stage[STAGES-1].q.carry;
  assign ovf       = g_stage[STAGES-1].q.ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4); honours PIPE_ADDER_SUB_EN like the DUT.
module tb_pipe_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned STG = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipe_adder #(.WIDTH(W), .STAGES(STG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .cin      (cin_i),
    .sub      (sub_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  int   checks  = 0;
  int   errors  = 0;
  int   emitted = 0;
  res_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int   ia, ib, sa, sb, ires, sres;
    logic do_sub;
`ifdef PIPE_ADDER_SUB_EN
    do_sub = sub;
`else
    do_sub = 1'b0;
`endif
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (do_sub) begin
      ires   = ia - ib - int'(cin);
      sres   = sa - sb - int'(cin);
      r.cout = (ires >= 0);
    end else begin
      ires   = ia + ib + int'(cin);
      sres   = sa + sb + int'(cin);
      r.cout = (ires >= 65536);
    end
    r.sum = ires[W-1:0];
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  // Scoreboard: sample handshakes on the falling edge, i.e. what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        emitted++;
        check("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          res_t e;
          e = exp_q.pop_front();
          check("sb_sum", 32'(sum), 32'(e.sum));
          check("sb_cout", 32'(cout), 32'(e.cout));
          check("sb_ovf", 32'(ovf), 32'(e.ovf));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_i, b_i, cin_i, sub_i));
    end
  end

  task automatic apply_vec(input vec_t v);
    int edges;
    @(posedge clk); #1;
    out_ready = 1'b1;
    a_i = v.a; b_i = v.b; cin_i = v.cin; sub_i = v.sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
    check({v.name, "_latency"}, 32'(edges), 32'(STG));
    check({v.name, "_sum"}, 32'(sum), 32'(v.exp_sum));
    check({v.name, "_cout"}, 32'(cout), 32'(v.exp_cout));
    check({v.name, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
  endtask

  initial begin
    vec_t         vecs[5];
    logic [W-1:0] ra[8];
    logic [W-1:0] rb[8];
    logic         rc[8];
    logic         rs[8];
    int           idx, start_emit, ghost;
    logic         acc;

    vecs[0] = '{"carry8",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{"fullprop", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"sovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`ifdef PIPE_ADDER_SUB_EN
    vecs[4] = '{"sub5m7",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
`else
    vecs[4] = '{"sub5m7",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
`endif

    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    // Back-to-back random stream with a three-cycle consumer stall.
    for (int i = 0; i < 8; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    @(posedge clk); #1;
    idx = 0;
    acc = 1'b0;
    start_emit = emitted;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      in_valid = (idx < 8);
      if (idx < 8) begin
        a_i = ra[idx]; b_i = rb[idx]; cin_i = rc[idx]; sub_i = rs[idx];
      end
      out_ready = !(cyc >= 6 && cyc < 9);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (cyc >= 6 && cyc < 9) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (idx == 8 && (emitted - start_emit) >= 8) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", 32'(emitted - start_emit), 32'd8);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three transactions in flight, the oldest stalled at the output.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'b0; sub_i = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("inflight_out_valid", 32'(out_valid), 32'd1);
    check("inflight_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    ghost = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    check("no_ghost_after_reset", 32'(ghost), 32'd0);
    apply_vec(vecs[0]);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready stream interface. It is the next generation of the team's 4-bit ripple adder. The WIDTH-bit carry chain is split into STAGES equal chunks, and each chunk is registered, so wide adds close timing at high clock rates. It sits between an operand-producing stream source and a result consumer, and it applies backpressure.

## Interface
- WIDTH, 16: operand and result width in bits. Must be divisible by STAGES.
- STAGES, 4: number of pipeline stages. Range 1..WIDTH. Chunk width is CHUNK = WIDTH/STAGES.
- clk, input, 1: the single clock. All state updates on its rising edge.
- rst_n, input, 1: asynchronous reset, active-low.
- in_valid, input, 1: operands present.
- in_ready, output, 1: block accepts operands this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in for add, borrow-in for subtract.
- sub, input, 1: 1 selects subtract. Only honoured with PIPE_ADDER_SUB_EN.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH: result.
- cout, output, 1: raw carry out of the MSB.
- ovf, output, 1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- Accept happens when in_valid && in_ready. Emit happens when out_valid && out_ready.
- Global stall enable: en = !out_valid || out_ready. in_ready = en. Every stage register, including the valid bits, updates only when en=1.
- Stage 0 adds chunk 0 of the operands with the effective carry-in. It registers the chunk-0 sum, the carry, and the upper operand chunks still to be added.
- Stage k (k ≥ 1) adds chunk k using the carry from stage k-1. It forwards the already-computed low chunks and any remaining operand chunks.
- The final stage registers sum, cout and ovf. These registers drive the outputs directly.
- Subtract: b is inverted and the effective carry-in is ~cin, so the result is a − b − cin. cout=1 means no borrow.
- Bubbles are not collapsed. A stage whose valid bit is 0 still occupies a slot, and throughput is one result per cycle while out_ready=1.
- Arithmetic is modulo 2^WIDTH and no saturation is applied.
- in_valid=1 while in_ready=0: the operands are not taken, and the source must hold them stable.
- Reset mid-operation clears all in-flight transactions. None of them emerge after rst_n rises.
- Reset values: every valid bit is 0 and every data register is 0. Therefore out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1 (because out_valid=0).

## Timing
- Latency: a transaction accepted at rising edge n is visible on the outputs after edge n+STAGES−1. This counts STAGES edges including the accept edge. With STAGES=1 the block is a single registered adder.
- in_ready is combinational from out_valid and out_ready only. There is no combinational path from in_valid, a or b to any output.
- The critical path is one CHUNK-bit ripple plus the input mux for subtract.
- A stall with out_ready=0 freezes the whole pipe in the same cycle it is observed. in_ready drops in that cycle.
- Asynchronous assertion of rst_n forces outputs to their reset values without waiting for a clock edge.

## Configuration
- PIPE_ADDER_SUB_EN defined: the sub port is honoured and the block adds or subtracts per transaction. The sub value is captured with the operands and travels with its transaction.
- PIPE_ADDER_SUB_EN undefined: the sub port is present but ignored, the block always adds, and the b-invert mux is not built.

## Structure
- Package pipe_adder_pkg holds:
  - the op_e enum (OP_ADD, OP_SUB);
  - the per-stage payload struct typedef (valid, partial sum, carry, remaining a/b chunks);
  - a localparam helper computing CHUNK, plus an elaboration check that WIDTH % STAGES == 0.
- Sub-module adder_chunk: a CHUNK-bit combinational ripple built from the existing fulladder cell. It outputs the chunk sum, the carry-out, and the carry into its MSB (the last of these is used for ovf in the top chunk). pipe_adder instantiates STAGES copies of it in a generate loop.

## Test plan
- WIDTH=16, STAGES=4: a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0, ovf=0, with out_valid rising exactly 4 edges after accept (accept edge counted).
- Full carry propagation: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Stream 8 back-to-back random transactions, dropping out_ready for 3 cycles mid-stream → in_ready is low during those cycles, all 8 results arrive in order with none lost or duplicated, and each matches the reference model.
- Same stimulus in both builds: a=5, b=7, cin=0, sub=1.
  - With PIPE_ADDER_SUB_EN: sum=0xFFFE, cout=0, ovf=0.
  - Without the macro: sum=0x000C, cout=0.
- Assert rst_n with 3 transactions in flight → out_valid=0 immediately. After release, no result emerges until new input is accepted.
